// File: rtl/parity_serial_tx_pkg.sv
// ============================================================================
// Module : parity_serial_tx_pkg
// Brief  : Shared FSM state type, frame length and parity mode constants.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package parity_serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int   FRAME_BITS = 11;
    localparam logic PAR_ODD    = 1'b0;
    localparam logic PAR_EVEN   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/parity_gen8.sv
// ============================================================================
// Module : parity_gen8
// Brief  : Combinational parity of one byte; even mode is the XOR of the
//          data bits, odd mode its inverse. Shared with the receive checker.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_gen8
    import parity_serial_tx_pkg::*;
(
    input  logic [7:0] i_data,
    input  logic       i_mode,
    output logic       o_par
);

    assign o_par = (^i_data) ^ (i_mode == PAR_ODD);

endmodule

`default_nettype wire

// File: rtl/parity_serial_tx.sv
// ============================================================================
// Module : parity_serial_tx
// Brief  : 8-bit serial transmitter, frame = start, 8 data LSB first,
//          parity, stop. Optional parity error injection under the macro
//          PARITY_TX_ERR_INJECT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_serial_tx
    import parity_serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       O_E,
    input  logic       tx_valid,
`ifdef PARITY_TX_ERR_INJECT_EN
    input  logic       err_inj,
`endif
    output logic       tx_ready,
    output logic       tx_serial,
    output logic       tx_par,
    output logic       busy
);

    localparam int          CNT_W        = 16;
    localparam logic [CNT_W-1:0] c_cnt_reload = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [2:0]       w_idx_inc;
    logic [7:0]       r_data;
    logic [7:0]       w_data_nxt;
    logic             r_par;
    logic             w_par_nxt;
    logic             r_serial;
    logic             w_serial_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             w_par_gen;
    logic             w_inj;
    logic             w_bit_done;

    parity_gen8 u_parity_gen8 (
        .i_data (tx_data),
        .i_mode (O_E),
        .o_par  (w_par_gen)
    );

`ifdef PARITY_TX_ERR_INJECT_EN
    assign w_inj = err_inj;
`else
    assign w_inj = 1'b0;
`endif

    assign w_bit_done = (r_cnt == '0);
    assign w_idx_inc  = r_idx + 3'd1;

    // Every bit boundary reloads the period counter; otherwise it counts down.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_data_nxt   = r_data;
        w_par_nxt    = r_par;
        w_serial_nxt = r_serial;
        w_busy_nxt   = r_busy;

        case (r_state)
            IDLE: begin
                w_serial_nxt = 1'b1;
                w_busy_nxt   = 1'b0;
                if (tx_valid) begin
                    w_state_nxt  = START;
                    w_data_nxt   = tx_data;
                    w_par_nxt    = w_par_gen ^ w_inj;
                    w_serial_nxt = 1'b0;
                    w_busy_nxt   = 1'b1;
                    w_cnt_nxt    = c_cnt_reload;
                    w_idx_nxt    = 3'd0;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_state_nxt  = DATA;
                    w_serial_nxt = r_data[0];
                    w_idx_nxt    = 3'd0;
                    w_cnt_nxt    = c_cnt_reload;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            DATA: begin
                if (w_bit_done) begin
                    w_cnt_nxt = c_cnt_reload;
                    if (r_idx == 3'd7) begin
                        w_state_nxt  = PARITY;
                        w_serial_nxt = r_par;
                    end else begin
                        w_idx_nxt    = w_idx_inc;
                        w_serial_nxt = r_data[w_idx_inc];
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            PARITY: begin
                if (w_bit_done) begin
                    w_state_nxt  = STOP;
                    w_serial_nxt = 1'b1;
                    w_cnt_nxt    = c_cnt_reload;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            STOP: begin
                if (w_bit_done) begin
                    w_state_nxt  = IDLE;
                    w_serial_nxt = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_cnt_nxt    = '0;
                    w_idx_nxt    = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_serial_nxt = 1'b1;
                w_busy_nxt   = 1'b0;
                w_cnt_nxt    = '0;
                w_idx_nxt    = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= 3'd0;
            r_data   <= 8'h00;
            r_par    <= 1'b0;
            r_serial <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_data   <= w_data_nxt;
            r_par    <= w_par_nxt;
            r_serial <= w_serial_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign tx_ready  = (r_state == IDLE);
    assign tx_serial = r_serial;
    assign tx_par    = r_par;
    assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_parity_serial_tx.sv
// ============================================================================
// Module : tb_parity_serial_tx
// Brief  : Directed self-checking bench for parity_serial_tx at
//          CLKS_PER_BIT=4 and CLKS_PER_BIT=1.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity_serial_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] data4, data1;
    logic       oe4, oe1;
    logic       valid4, valid1;
    logic       ready4, ready1;
    logic       ser4, ser1;
    logic       par4, par1;
    logic       busy4, busy1;
`ifdef PARITY_TX_ERR_INJECT_EN
    logic       inj4, inj1;
`endif

    int n_vec;
    int n_err;

    parity_serial_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (data4),
        .O_E       (oe4),
        .tx_valid  (valid4),
`ifdef PARITY_TX_ERR_INJECT_EN
        .err_inj   (inj4),
`endif
        .tx_ready  (ready4),
        .tx_serial (ser4),
        .tx_par    (par4),
        .busy      (busy4)
    );

    parity_serial_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (data1),
        .O_E       (oe1),
        .tx_valid  (valid1),
`ifdef PARITY_TX_ERR_INJECT_EN
        .err_inj   (inj1),
`endif
        .tx_ready  (ready1),
        .tx_serial (ser1),
        .tx_par    (par1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Walks one frame from the cycle after the accept edge; ends in the first idle cycle.
    task automatic run_frame(input bit sel, input logic [0:10] bits, input int n,
                             input string tag);
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < n; c++) begin
                check({tag, "_ser"},   sel ? ser1 : ser4, bits[b]);
                check({tag, "_busy"},  sel ? busy1 : busy4, 1'b1);
                check({tag, "_ready"}, sel ? ready1 : ready4, 1'b0);
                tick();
            end
        end
        check({tag, "_end_ready"}, sel ? ready1 : ready4, 1'b1);
        check({tag, "_end_busy"},  sel ? busy1 : busy4, 1'b0);
        check({tag, "_end_ser"},   sel ? ser1 : ser4, 1'b1);
    endtask

    task automatic send4(input logic [7:0] d, input logic oe);
        data4  = d;
        oe4    = oe;
        valid4 = 1'b1;
        tick();
        valid4 = 1'b0;
        data4  = ~d;
        oe4    = ~oe;
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        data4  = 8'h00; oe4 = 1'b0; valid4 = 1'b0;
        data1  = 8'h00; oe1 = 1'b0; valid1 = 1'b0;
`ifdef PARITY_TX_ERR_INJECT_EN
        inj4 = 1'b0; inj1 = 1'b0;
`endif
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst_ser",   ser4,   1'b1);
        check("rst_busy",  busy4,  1'b0);
        check("rst_ready", ready4, 1'b1);
        check("rst_par",   par4,   1'b0);
        check("rst_ser1",  ser1,   1'b1);
        tick();
        check("idle_ser",  ser4,   1'b1);

        // A5 even: parity 0; inputs scrambled after accept must not matter
        send4(8'hA5, 1'b1);
        check("a5e_par", par4, 1'b0);
        run_frame(1'b0, 11'b01010010101, 4, "a5e");
        check("a5e_par_hold", par4, 1'b0);

        send4(8'hA5, 1'b0);
        check("a5o_par", par4, 1'b1);
        run_frame(1'b0, 11'b01010010111, 4, "a5o");

        send4(8'h01, 1'b1);
        check("01e_par", par4, 1'b1);
        run_frame(1'b0, 11'b01000000011, 4, "01e");

        send4(8'h00, 1'b0);
        check("00o_par", par4, 1'b1);
        run_frame(1'b0, 11'b00000000011, 4, "00o");

        // Back-to-back with tx_valid held: 3C then FF, one idle cycle between
        data4  = 8'h3C;
        oe4    = 1'b1;
        valid4 = 1'b1;
        tick();
        data4  = 8'hFF;
        check("3c_par", par4, 1'b0);
        run_frame(1'b0, 11'b00011110001, 4, "3c");
        tick();
        valid4 = 1'b0;
        check("ff_ready_low", ready4, 1'b0);
        check("ff_par", par4, 1'b0);
        run_frame(1'b0, 11'b01111111101, 4, "ff");

        // Reset during data bit 3 of an odd-parity A5 frame
        send4(8'hA5, 1'b0);
        check("pre_rst_par", par4, 1'b1);
        repeat (17) tick();
        check("pre_rst_ser", ser4, 1'b0);
        rst_n  = 1'b0;
        data4  = 8'h01;
        oe4    = 1'b1;
        valid4 = 1'b1;
        tick();
        check("mid_rst_ser",   ser4,   1'b1);
        check("mid_rst_busy",  busy4,  1'b0);
        check("mid_rst_ready", ready4, 1'b1);
        check("mid_rst_par",   par4,   1'b0);
        tick();
        check("rst_no_accept_busy", busy4, 1'b0);
        check("rst_no_accept_ser",  ser4,  1'b1);
        rst_n = 1'b1;
        tick();
        valid4 = 1'b0;
        check("post_rst_par", par4, 1'b1);
        run_frame(1'b0, 11'b01000000011, 4, "post_rst");

        // One clock per bit
        data1  = 8'h80;
        oe1    = 1'b1;
        valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        data1  = 8'h00;
        check("cpb1_par", par1, 1'b1);
        run_frame(1'b1, 11'b00000000111, 1, "cpb1");

`ifdef PARITY_TX_ERR_INJECT_EN
        inj4 = 1'b1;
        send4(8'hA5, 1'b1);
        inj4 = 1'b0;
        check("inj_par", par4, 1'b1);
        run_frame(1'b0, 11'b01010010111, 4, "inj");
        inj4 = 1'b0;
        send4(8'hA5, 1'b1);
        inj4 = 1'b1;
        check("noinj_par", par4, 1'b0);
        run_frame(1'b0, 11'b01010010101, 4, "noinj");
        inj4 = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
